adc_scan_sampler: RTL and testbench

Parametrised successor to the fixed 4-channel, 8-bit ADC sampler. It controls a multiplexed parallel-output ADC using the n_convst, n_eoc, n_cs and n_rd strobes, scanning channels 0..NCH-1 on a programmable period. Each result is emitted as a single-cycle stream beat and also held in a per-channel register bank. It sits between the ADC pins and the beamforming/delay datapath, and adds an EOC timeout and overrun detection.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_period_timer.sv | 32 +++
 rtl/adc_scan_sampler.sv | 122 ++++++++++++
 tb/tb_adc_scan_sampler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC scan sampler and downstream datapath.
package adc_pkg;
  localparam int ADC_CHSEL_W = 3;
  localparam int ADC_DW_DEF  = 8;
  localparam int ADC_NCH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CONV,
    WAIT_EOC,
    READ,
    NEXT
  } adc_state_t;
endpackage

// File: rtl/adc_period_timer.sv
// Scan-period counter: issues a scan start when idle, or an overrun event when busy.
module adc_period_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  input  logic             idle,
  output logic             start,
  output logic             drop
);
  logic [DIV_W-1:0] cnt;
  logic             tick;

  assign tick  = enable && (cnt == '0);
  assign start = tick && idle;
  // period=0 ticks every cycle; those ticks only mean "start when idle", never overrun
  assign drop  = tick && !idle && (period != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= (period == '0) ? '0 : period - DIV_W'(1);
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end
endmodule

// File: rtl/adc_scan_sampler.sv
// Multiplexed parallel ADC scanner: strobe sequencing, EOC timeout, sample bank and stream.
module adc_scan_sampler
  import adc_pkg::*;
#(
  parameter int NCH      = ADC_NCH_DEF,
  parameter int DW       = ADC_DW_DEF,
  parameter int DIV_W    = 16,
  parameter int CONV_CYC = 2,
  parameter int RD_CYC   = 3,
  parameter int EOC_TO   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       period,
  output logic [ADC_CHSEL_W-1:0] chnl,
  output logic                   n_convst,
  input  logic                   n_eoc,
  output logic                   n_cs,
  output logic                   n_rd,
  input  logic [DW-1:0]          adc_in,
  output logic [NCH*DW-1:0]      samples,
  output logic [DW-1:0]          stream_data,
  output logic [ADC_CHSEL_W-1:0] stream_ch,
  output logic                   stream_valid,
  output logic                   scan_done,
  output logic                   overrun,
  output logic                   timeout_err
);
  adc_state_t             state, nxt;
  logic [ADC_CHSEL_W-1:0] ch_idx, ch_nxt;
  logic [15:0]            cyc;
  logic [1:0]             eoc_s;
  logic                   start, drop, capture, timeout_hit;

  adc_period_timer #(.DIV_W(DIV_W)) u_timer (
    .clk    (clk),
    .rst    (reset),
    .enable (enable),
    .period (period),
    .idle   (state == IDLE),
    .start  (start),
    .drop   (drop)
  );

  always_comb begin
    nxt         = state;
    ch_nxt      = ch_idx;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (start) begin
        nxt    = SETUP;
        ch_nxt = '0;
      end
      SETUP: nxt = CONV;
      CONV: if (cyc == 16'(CONV_CYC - 1)) nxt = WAIT_EOC;
      WAIT_EOC: begin
        if (!eoc_s[1]) begin
          nxt = READ;
        end else if (cyc == 16'(EOC_TO - 1)) begin
          nxt         = NEXT;
          timeout_hit = 1'b1;
        end
      end
      READ: if (cyc == 16'(RD_CYC - 1)) begin
        nxt     = NEXT;
        capture = 1'b1;
      end
      NEXT: begin
        if (ch_idx == ADC_CHSEL_W'(NCH - 1)) begin
          nxt = IDLE;
        end else begin
          nxt    = SETUP;
          ch_nxt = ch_idx + 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Strobes and chnl are registered from the next state so they align with the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ch_idx       <= '0;
      cyc          <= '0;
      eoc_s        <= 2'b11;
      chnl         <= '0;
      n_convst     <= 1'b1;
      n_cs         <= 1'b1;
      n_rd         <= 1'b1;
      samples      <= '0;
      stream_data  <= '0;
      stream_ch    <= '0;
      stream_valid <= 1'b0;
      scan_done    <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= nxt;
      ch_idx       <= ch_nxt;
      cyc          <= (nxt != state) ? '0 : cyc + 16'd1;
      eoc_s        <= {eoc_s[0], n_eoc};
      n_convst     <= (nxt != CONV);
      n_cs         <= (nxt != READ);
      n_rd         <= (nxt != READ);
      stream_valid <= capture;
      scan_done    <= (nxt == NEXT) && (ch_idx == ADC_CHSEL_W'(NCH - 1));
      if (nxt == SETUP) chnl <= ch_nxt;
      if (capture) begin
        stream_data <= adc_in;
        stream_ch   <= ch_idx;
      end
      for (int unsigned k = 0; k < NCH; k++) begin
        if (capture && ch_idx == ADC_CHSEL_W'(k)) samples[k*DW +: DW] <= adc_in;
      end
      if (drop) overrun <= 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_adc_scan_sampler.sv
// Scoreboard bench for adc_scan_sampler with a behavioural ADC model.
module tb_adc_scan_sampler;
  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DIV_W = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [DIV_W-1:0]   period;
  logic [2:0]         chnl;
  logic               n_convst, n_cs, n_rd;
  logic               n_eoc = 1'b1;
  logic [DW-1:0]      adc_in = '0;
  logic [NCH*DW-1:0]  samples;
  logic [DW-1:0]      stream_data;
  logic [2:0]         stream_ch;
  logic               stream_valid, scan_done, overrun, timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc_scan_sampler #(
    .NCH(NCH), .DW(DW), .DIV_W(DIV_W), .CONV_CYC(2), .RD_CYC(3), .EOC_TO(255)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period), .chnl(chnl),
    .n_convst(n_convst), .n_eoc(n_eoc), .n_cs(n_cs), .n_rd(n_rd), .adc_in(adc_in),
    .samples(samples), .stream_data(stream_data), .stream_ch(stream_ch),
    .stream_valid(stream_valid), .scan_done(scan_done), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] ch;
    logic [7:0] d;
  } beat_t;
  beat_t exp_q[$];

  // ADC model: EOC a few clocks after n_convst rises, data valid only on the 3rd n_rd-low clock
  logic [7:0] base = 8'h10;
  int no_eoc_ch = -1;
  int eoc_delay = 5;
  int eoc_cnt = 0;
  bit armed = 0;
  logic prev_convst_m = 1'b1;
  int rd_k = 0;

  always @(negedge clk) begin
    if (reset) begin
      armed = 0; n_eoc = 1'b1; prev_convst_m = 1'b1; rd_k = 0; adc_in = '0;
    end else begin
      if (!prev_convst_m && n_convst) begin
        armed   = (int'(chnl) != no_eoc_ch);
        eoc_cnt = eoc_delay;
      end
      prev_convst_m = n_convst;
      if (armed) begin
        eoc_cnt--;
        if (eoc_cnt == 0) begin
          n_eoc = 1'b0;
          armed = 0;
          exp_q.push_back('{chnl, base + 8'(chnl)});
        end
      end
      if (!n_rd) begin
        n_eoc = 1'b1;
        rd_k++;
      end else begin
        rd_k = 0;
      end
      adc_in = (!n_rd && rd_k == 3) ? base + 8'(chnl) : 8'hEE;
    end
  end

  int beats = 0;
  beat_t e;
  always @(negedge clk) begin
    if (!reset && stream_valid) begin
      beats++;
      if (exp_q.size() == 0) begin
        check_val("beat_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("beat_ch", 32'(stream_ch), 32'(e.ch));
        check_val("beat_data", 32'(stream_data), 32'(e.d));
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int cv_len = 0, rd_len = 0, starts = 0, dones = 0;
  int last_start = 0, t_done = 0, gap = 0, t_rise = 0, to_delay = 0;
  logic [2:0] ch_lat = '0;
  logic prev_cv = 1'b1, prev_cs = 1'b1, prev_to = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      cv_len = 0; rd_len = 0; prev_cv = 1'b1; prev_cs = 1'b1; prev_to = 1'b0;
    end else begin
      if (!n_convst) begin
        if (prev_cv) begin
          ch_lat = chnl;
          if (chnl == 3'd0) begin
            starts++;
            last_start = cyc;
            gap = cyc - t_done;
          end
        end
        cv_len++;
      end else if (!prev_cv) begin
        check_val("convst_len", 32'(cv_len), 32'd2);
        cv_len = 0;
        t_rise = cyc;
      end
      if (!n_cs) begin
        rd_len++;
      end else if (!prev_cs) begin
        check_val("rd_len", 32'(rd_len), 32'd3);
        check_val("chnl_stable", 32'(chnl), 32'(ch_lat));
        rd_len = 0;
      end
      if (n_cs != n_rd) check_val("cs_rd_align", 32'(n_rd), 32'(n_cs));
      if (scan_done) begin
        dones++;
        t_done = cyc;
      end
      if (timeout_err && !prev_to) to_delay = cyc - t_rise;
      prev_cv = n_convst;
      prev_cs = n_cs;
      prev_to = timeout_err;
    end
  end

  task automatic wait_done(input string tag, input int budget);
    int n0 = dones;
    int k = 0;
    while (dones == n0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (dones == n0) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_rd_ch1(input string tag, input int budget);
    int k = 0;
    while (!(chnl == 3'd1 && !n_cs) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (!(chnl == 3'd1 && !n_cs)) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_convst(input string tag, input int budget);
    int k = 0;
    while (n_convst && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_convst) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1 exp_q.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  int first_start, sn, dn, b0;

  initial begin
    reset = 1'b1; enable = 1'b0; period = '0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_chnl", 32'(chnl), 32'd0);
    check_val("rst_strobes", {29'd0, n_convst, n_cs, n_rd}, 32'd7);
    check_val("rst_samples", samples, 32'd0);
    check_val("rst_stream", {21'd0, stream_ch, stream_data}, 32'd0);
    check_val("rst_flags", {28'd0, stream_valid, scan_done, overrun, timeout_err}, 32'd0);
    reset = 1'b0;

    // nominal scans, period 200
    period = 16'd200; enable = 1'b1;
    wait_done("t1_done0_timeout", 400);
    check_val("t1_samples", samples, 32'h13121110);
    first_start = last_start;
    wait_done("t1_done1_timeout", 400);
    enable = 1'b0;
    check_val("t1_period", 32'(last_start - first_start), 32'd200);
    check_val("t1_beats", 32'(beats), 32'd8);
    check_val("t1_flags", {30'd0, overrun, timeout_err}, 32'd0);
    repeat (20) @(negedge clk);

    // channel 2 never converts
    base = 8'h20; no_eoc_ch = 2; period = 16'd2000; enable = 1'b1;
    wait_done("t3_done_timeout", 1500);
    enable = 1'b0;
    check_val("t3_timeout_err", 32'(timeout_err), 32'd1);
    check_val("t3_timeout_delay", 32'(to_delay), 32'd255);
    check_val("t3_samples", samples, 32'h23122120);
    check_val("t3_beats", 32'(beats), 32'd11);
    repeat (20) @(negedge clk);
    check_val("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // period shorter than a scan
    do_reset();
    base = 8'h30; no_eoc_ch = -1; period = 16'd10; sn = starts; enable = 1'b1;
    wait_done("t4_done_timeout", 400);
    check_val("t4_overrun", 32'(overrun), 32'd1);
    check_val("t4_single_scan", 32'(starts - sn), 32'd1);
    check_val("t4_samples", samples, 32'h33323130);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    check_val("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // back-to-back scans, then enable dropped mid-scan
    do_reset();
    base = 8'h40; period = '0; enable = 1'b1;
    wait_done("t5_done0_timeout", 400);
    wait_done("t5_done1_timeout", 400);
    // scan_done is seen in NEXT, then one IDLE and one SETUP cycle precede CONV
    check_val("t5_idle_gap", 32'(gap), 32'd3);
    check_val("t5_overrun", 32'(overrun), 32'd0);
    wait_rd_ch1("t5_rd_ch1_timeout", 200);
    enable = 1'b0;
    sn = starts; dn = dones;
    wait_done("t5_finish_timeout", 200);
    repeat (100) @(negedge clk);
    check_val("t5_no_restart", 32'(starts), 32'(sn));
    check_val("t5_one_done", 32'(dones), 32'(dn + 1));
    check_val("t5_samples", samples, 32'h43424140);
    check_val("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset during READ of channel 1
    base = 8'h50; period = 16'd1000; enable = 1'b1;
    wait_rd_ch1("t6_rd_ch1_timeout", 200);
    reset = 1'b1;
    #1;
    check_val("t6_cs_rd", {30'd0, n_cs, n_rd}, 32'd3);
    check_val("t6_convst", 32'(n_convst), 32'd1);
    check_val("t6_chnl", 32'(chnl), 32'd0);
    check_val("t6_samples", samples, 32'd0);
    check_val("t6_stream", {21'd0, stream_ch, stream_data}, 32'd0);
    check_val("t6_flags", {28'd0, stream_valid, scan_done, overrun, timeout_err}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    wait_convst("t6_restart_timeout", 50);
    check_val("t6_restart_ch", 32'(chnl), 32'd0);
    wait_done("t6_done_timeout", 400);
    enable = 1'b0;
    check_val("t6_samples_after", samples, 32'h53525150);
    repeat (100) @(negedge clk);
    check_val("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
